// File: rtl/display_scheduler.sv
// Display sequencer: shows the live base word, or a held (optionally blinking) message
// from one of two prioritised requesters.
module display_scheduler #(
    parameter int HOLD_TICKS  = 50_000_000,
    parameter int BLINK_TICKS = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] base_graphics,
    input  logic        hi_valid,
    input  logic [15:0] hi_graphics,
    input  logic        hi_blink,
    output logic        hi_ready,
    input  logic        lo_valid,
    input  logic [15:0] lo_graphics,
    input  logic        lo_blink,
    output logic        lo_ready,
    input  logic        clear,
    output logic [15:0] graphics,
    output logic        busy,
    output logic [1:0]  src
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_LO = 2'd1,
        SHOW_HI = 2'd2
    } state_t;

    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_TICKS - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_TICKS - 1);

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] bcnt_q, bcnt_d;
    logic        phase_q, phase_d;
    logic        blink_q, blink_d;
    logic [15:0] msg_q, msg_d;
    logic [15:0] graphics_q, graphics_d;

    logic expiring_s;
    logic hi_xfer_s;
    logic lo_xfer_s;

    // Handshake readiness; held low while in reset so nothing is accepted.
    always_comb begin
        expiring_s = (state_q != IDLE) && (hold_q == HOLD_LAST);
        hi_ready   = !rst && !clear &&
                     (state_q == IDLE || state_q == SHOW_LO || expiring_s);
        lo_ready   = !rst && !clear && !hi_valid &&
                     (state_q == IDLE || expiring_s);
        hi_xfer_s  = hi_valid && hi_ready;
        lo_xfer_s  = lo_valid && lo_ready;
    end

    // Next-state, counters and capture registers.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        blink_d = blink_q;
        msg_d   = msg_q;
        if (hi_xfer_s) begin
            state_d = SHOW_HI;
            msg_d   = hi_graphics;
            blink_d = hi_blink;
            hold_d  = 32'd0;
            bcnt_d  = 32'd0;
            phase_d = 1'b1;
        end else if (lo_xfer_s) begin
            state_d = SHOW_LO;
            msg_d   = lo_graphics;
            blink_d = lo_blink;
            hold_d  = 32'd0;
            bcnt_d  = 32'd0;
            phase_d = 1'b1;
        end else if (clear || expiring_s) begin
            state_d = IDLE;
            hold_d  = 32'd0;
            bcnt_d  = 32'd0;
            phase_d = 1'b1;
        end else if (state_q != IDLE) begin
            hold_d = hold_q + 32'd1;
            if (blink_q) begin
                if (bcnt_q == BLINK_LAST) begin
                    bcnt_d  = 32'd0;
                    phase_d = !phase_q;
                end else begin
                    bcnt_d = bcnt_q + 32'd1;
                end
            end else begin
                bcnt_d = bcnt_q;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // Output word is derived from the next state so it lines up with the state register.
    always_comb begin
        graphics_d = 16'hFFFF;
        case (state_d)
            IDLE:    graphics_d = base_graphics;
            SHOW_LO,
            SHOW_HI: begin
                if (blink_d && !phase_d) begin
                    graphics_d = 16'hFFFF;
                end else begin
                    graphics_d = msg_d;
                end
            end
            default: graphics_d = 16'hFFFF;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= 32'd0;
            bcnt_q     <= 32'd0;
            phase_q    <= 1'b1;
            blink_q    <= 1'b0;
            msg_q      <= 16'hFFFF;
            graphics_q <= 16'hFFFF;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            blink_q    <= blink_d;
            msg_q      <= msg_d;
            graphics_q <= graphics_d;
        end
    end

    assign graphics = graphics_q;
    assign busy     = (state_q != IDLE);
    assign src      = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with HOLD_TICKS=8, BLINK_TICKS=2.
module tb_display_scheduler;
    logic        clk;
    logic        rst;
    logic [15:0] base_graphics;
    logic        hi_valid;
    logic [15:0] hi_graphics;
    logic        hi_blink;
    logic        hi_ready;
    logic        lo_valid;
    logic [15:0] lo_graphics;
    logic        lo_blink;
    logic        lo_ready;
    logic        clear;
    logic [15:0] graphics;
    logic        busy;
    logic [1:0]  src;

    int checks   = 0;
    int failures = 0;

    display_scheduler #(.HOLD_TICKS(8), .BLINK_TICKS(2)) dut (
        .clk(clk), .rst(rst), .base_graphics(base_graphics),
        .hi_valid(hi_valid), .hi_graphics(hi_graphics), .hi_blink(hi_blink), .hi_ready(hi_ready),
        .lo_valid(lo_valid), .lo_graphics(lo_graphics), .lo_blink(lo_blink), .lo_ready(lo_ready),
        .clear(clear), .graphics(graphics), .busy(busy), .src(src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] g, input logic b, input logic [1:0] s);
        chk({tag, ".graphics"}, 32'(graphics), 32'(g));
        chk({tag, ".busy"},     32'(busy),     32'(b));
        chk({tag, ".src"},      32'(src),      32'(s));
    endtask

    initial begin
        logic [15:0] blink_seq [8];
        blink_seq[0] = 16'hAAAE; blink_seq[1] = 16'hAAAE;
        blink_seq[2] = 16'hFFFF; blink_seq[3] = 16'hFFFF;
        blink_seq[4] = 16'hAAAE; blink_seq[5] = 16'hAAAE;
        blink_seq[6] = 16'hFFFF; blink_seq[7] = 16'hFFFF;

        rst = 1'b1; base_graphics = 16'h1234;
        hi_valid = 1'b0; hi_graphics = 16'h0000; hi_blink = 1'b0;
        lo_valid = 1'b0; lo_graphics = 16'h0000; lo_blink = 1'b0;
        clear = 1'b0;

        // Reset state and release
        repeat (2) @(negedge clk);
        #1;
        chk_out("reset", 16'hFFFF, 1'b0, 2'd0);
        chk("reset.hi_ready", 32'(hi_ready), 32'd0);
        chk("reset.lo_ready", 32'(lo_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("release.graphics_before_edge", 32'(graphics), 32'h0000FFFF);
        @(negedge clk);
        chk_out("release", 16'h1234, 1'b0, 2'd0);

        // Non-blinking lo message held for 8 cycles
        lo_valid = 1'b1; lo_graphics = 16'hDDDD; lo_blink = 1'b0;
        #1;
        chk("lo.lo_ready", 32'(lo_ready), 32'd1);
        @(negedge clk);
        lo_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("lo.hold%0d", i), 16'hDDDD, 1'b1, 2'd1);
            @(negedge clk);
        end
        chk_out("lo.expired", 16'h1234, 1'b0, 2'd0);
        base_graphics = 16'h5678;
        @(negedge clk);
        chk_out("base.latency", 16'h5678, 1'b0, 2'd0);

        // hi preempts lo at hold count 3, then blinks
        lo_valid = 1'b1; lo_graphics = 16'h0DDD;
        @(negedge clk);
        lo_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("preempt.lo_active", 16'h0DDD, 1'b1, 2'd1);
        hi_valid = 1'b1; hi_graphics = 16'hAAAE; hi_blink = 1'b1;
        #1;
        chk("preempt.hi_ready", 32'(hi_ready), 32'd1);
        chk("preempt.lo_ready", 32'(lo_ready), 32'd0);
        @(negedge clk);
        hi_valid = 1'b0; hi_blink = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blink.seq%0d", i), 32'(graphics), 32'(blink_seq[i]));
            chk($sformatf("blink.src%0d", i), 32'(src), 32'd2);
            @(negedge clk);
        end
        chk_out("blink.expired", 16'h5678, 1'b0, 2'd0);

        // Simultaneous hi and lo: hi first, lo back-to-back at expiry
        hi_valid = 1'b1; hi_graphics = 16'h0A0A;
        lo_valid = 1'b1; lo_graphics = 16'h0D0D;
        #1;
        chk("both.hi_ready", 32'(hi_ready), 32'd1);
        chk("both.lo_ready", 32'(lo_ready), 32'd0);
        @(negedge clk);
        hi_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_out($sformatf("both.hi%0d", i), 16'h0A0A, 1'b1, 2'd2);
            chk($sformatf("both.lo_ready%0d", i), 32'(lo_ready), (i == 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk_out("both.lo_b2b", 16'h0D0D, 1'b1, 2'd1);
        lo_valid = 1'b0;

        // clear wins over a simultaneous hi request
        @(negedge clk);
        clear = 1'b1; hi_valid = 1'b1; hi_graphics = 16'h1A2B;
        #1;
        chk("clear.hi_ready", 32'(hi_ready), 32'd0);
        chk("clear.lo_ready", 32'(lo_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk_out("clear.idle", 16'h5678, 1'b0, 2'd0);
        chk("clear.hi_ready_after", 32'(hi_ready), 32'd1);
        @(negedge clk);
        hi_valid = 1'b0;
        chk_out("clear.hi_taken", 16'h1A2B, 1'b1, 2'd2);

        // Asynchronous reset mid-message at hold count 5
        repeat (5) @(negedge clk);
        chk_out("rst.before", 16'h1A2B, 1'b1, 2'd2);
        rst = 1'b1;
        #1;
        chk_out("rst.async", 16'hFFFF, 1'b0, 2'd0);
        chk("rst.hi_ready", 32'(hi_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_out($sformatf("rst.after%0d", i), 16'h5678, 1'b0, 2'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
